// File: rtl/centroid_calc_pkg.sv
// Shared video-timing defaults and the centroid FSM state encoding.
package centroid_calc_pkg;

  localparam int DEF_H_ACTIVE = 64;
  localparam int DEF_V_ACTIVE = 64;
  localparam int DEF_XW       = 11;
  localparam int DEF_YW       = 10;
  localparam int DEF_ACC_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_X = 2'd1,
    DIV_Y = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/centroid_calc_divider_seq.sv
// Restoring unsigned divider: one quotient bit per cycle, done is high W cycles after start.
module divider_seq
  import centroid_calc_pkg::*;
#(
  parameter int W = DEF_ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [CW-1:0] cnt;
  logic          run;
  logic [2*W-1:0] step;

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                              input logic [W-1:0] q,
                                              input logic [W-1:0] d);
    logic [W:0]   sh;
    logic [W-1:0] diff;
    sh   = {r, q[W-1]};
    diff = sh[W-1:0] - d;
    if (sh >= {1'b0, d}) begin
      return {diff, q[W-2:0], 1'b1};
    end else begin
      return {sh[W-1:0], q[W-2:0], 1'b0};
    end
  endfunction

  always_comb begin
    step = {2*W{1'b0}};
    if (start) begin
      step = div_step({W{1'b0}}, dividend, divisor);
    end else begin
      step = div_step(rem, quotient, divisor);
    end
  end

  // The start cycle already performs the first step, so W-1 more steps follow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= {W{1'b0}};
      quotient <= {W{1'b0}};
      cnt      <= {CW{1'b0}};
      run      <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      {rem, quotient} <= step;
      cnt             <= CW'(W - 1);
      run             <= 1'b1;
      done            <= 1'b0;
    end else if (run) begin
      {rem, quotient} <= step;
      cnt             <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/centroid_calc.sv
// Accumulates object moments over a frame and divides them at frame end to get the centroid.
module centroid_calc
  import centroid_calc_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          de,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          mask,
  output logic [XW-1:0] x_c,
  output logic [YW-1:0] y_c,
  output logic          valid,
  output logic          no_obj,
  output logic          busy,
  output logic          overrun
);

  state_t state, state_next;

  logic             de_d, vsync_d, frame_end;
  logic [XW-1:0]    x_cnt, xq;
  logic [YW-1:0]    y_cnt;
  logic [ACC_W-1:0] m00, m10, m01;
  logic [ACC_W-1:0] op_m00, op_m10, op_m01;
  logic             kick, div_start, div_done;
  logic [ACC_W-1:0] div_dividend, div_quotient;
  logic             unused_ok;

  assign frame_end = vsync & ~vsync_d;
  assign unused_ok = ^{hsync, div_quotient[ACC_W-1:XW]};

  // Pixel coordinates; counters saturate at the active size so stray de cannot wrap them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d    <= 1'b0;
      vsync_d <= 1'b0;
      x_cnt   <= {XW{1'b0}};
      y_cnt   <= {YW{1'b0}};
    end else begin
      de_d    <= de;
      vsync_d <= vsync;
      if (de) begin
        if (x_cnt != XW'(H_ACTIVE - 1)) x_cnt <= x_cnt + XW'(1);
      end else begin
        x_cnt <= {XW{1'b0}};
      end
      if (vsync) begin
        y_cnt <= {YW{1'b0}};
      end else if (de_d && !de && (y_cnt != YW'(V_ACTIVE - 1))) begin
        y_cnt <= y_cnt + YW'(1);
      end
    end
  end

  // Moment accumulators; every frame end clears them, even one that arrives while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m00 <= {ACC_W{1'b0}};
      m10 <= {ACC_W{1'b0}};
      m01 <= {ACC_W{1'b0}};
    end else if (frame_end) begin
      m00 <= {ACC_W{1'b0}};
      m10 <= {ACC_W{1'b0}};
      m01 <= {ACC_W{1'b0}};
    end else if (de && mask) begin
      m00 <= m00 + ACC_W'(1);
      m10 <= m10 + ACC_W'(x_cnt);
      m01 <= m01 + ACC_W'(y_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_m00 <= {ACC_W{1'b0}};
      op_m10 <= {ACC_W{1'b0}};
      op_m01 <= {ACC_W{1'b0}};
    end else if ((state == IDLE) && frame_end) begin
      op_m00 <= m00;
      op_m10 <= m10;
      op_m01 <= m01;
    end
  end

  // Next-state logic; the y division is launched in the same cycle the x result appears.
  always_comb begin
    state_next   = state;
    div_start    = 1'b0;
    div_dividend = op_m10;
    case (state)
      IDLE: begin
        if (frame_end) begin
          state_next = (m00 == {ACC_W{1'b0}}) ? DONE : DIV_X;
        end else begin
          state_next = IDLE;
        end
      end
      DIV_X: begin
        div_start    = kick | div_done;
        div_dividend = div_done ? op_m01 : op_m10;
        if (div_done) begin
          state_next = DIV_Y;
        end else begin
          state_next = DIV_X;
        end
      end
      DIV_Y: begin
        if (div_done) begin
          state_next = DONE;
        end else begin
          state_next = DIV_Y;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs; valid coincides with the single DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      busy    <= 1'b0;
      kick    <= 1'b0;
      overrun <= 1'b0;
      no_obj  <= 1'b0;
      xq      <= {XW{1'b0}};
      x_c     <= {XW{1'b0}};
      y_c     <= {YW{1'b0}};
    end else begin
      valid <= (state_next == DONE);
      busy  <= (state_next != IDLE);
      kick  <= (state == IDLE) && (state_next == DIV_X);
      if (frame_end && (state != IDLE)) overrun <= 1'b1;
      if ((state == IDLE) && (state_next == DONE)) no_obj <= 1'b1;
      if ((state == DIV_X) && div_done) xq <= div_quotient[XW-1:0];
      if ((state == DIV_Y) && div_done) begin
        x_c    <= xq;
        y_c    <= div_quotient[YW-1:0];
        no_obj <= 1'b0;
      end
    end
  end

  divider_seq #(.W(ACC_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (op_m00),
    .quotient (div_quotient),
    .done     (div_done)
  );

endmodule

// File: tb/tb_centroid_calc.sv
// Randomised scoreboard bench for centroid_calc on an 8x8 frame.
module tb_centroid_calc;

  localparam int XW  = 11;
  localparam int YW  = 10;
  localparam int W   = 32;
  localparam int LAT = 2 * W + 2;

  logic          clk, rst, de, hsync, vsync, mask;
  logic [XW-1:0] x_c;
  logic [YW-1:0] y_c;
  logic          valid, no_obj, busy, overrun;

  centroid_calc #(.H_ACTIVE(8), .V_ACTIVE(8), .XW(XW), .YW(YW), .ACC_W(W)) dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .mask(mask),
    .x_c(x_c), .y_c(y_c), .valid(valid), .no_obj(no_obj), .busy(busy), .overrun(overrun)
  );

  typedef struct {
    int            cyc;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    bit            no_obj;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            busy_until = -1;
  bit            ovr_model = 1'b0;
  logic [XW-1:0] last_x = '0, cur_x = '0;
  logic [YW-1:0] last_y = '0, cur_y = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each valid; between pulses the outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cur_x = '0;
      cur_y = '0;
    end else if (valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got a pulse, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("x_c", x_c, e.x);
        check("y_c", y_c, e.y);
        check("no_obj", no_obj, e.no_obj);
        cur_x = e.x;
        cur_y = e.y;
      end
    end else begin
      check("hold_x", x_c, cur_x);
      check("hold_y", y_c, cur_y);
    end
  end

  task automatic drive_lines(input logic [63:0] fm);
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        @(negedge clk);
        de = 1'b1; hsync = 1'b0; mask = fm[y*8+x];
      end
      @(negedge clk);
      de = 1'b0; mask = 1'b0; hsync = 1'b1;
      repeat (3) begin
        @(negedge clk);
        hsync = 1'b0;
      end
    end
  endtask

  // Raise vsync and record what the frame just completed should produce.
  task automatic raise_vsync(input logic [63:0] fm, output int e);
    int   s00, s10, s01;
    exp_t ex;
    @(negedge clk);
    vsync = 1'b1; de = 1'b0; mask = 1'b0;
    e = cyc;
    if (e <= busy_until) begin
      ovr_model = 1'b1;
    end else begin
      s00 = 0; s10 = 0; s01 = 0;
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++)
          if (fm[y*8+x]) begin
            s00 += 1; s10 += x; s01 += y;
          end
      if (s00 == 0) begin
        ex = '{e + 1, last_x, last_y, 1'b1};
        busy_until = e + 1;
      end else begin
        last_x = XW'(s10 / s00);
        last_y = YW'(s01 / s00);
        ex = '{e + LAT, last_x, last_y, 1'b0};
        busy_until = e + LAT;
      end
      sb.push_back(ex);
    end
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic frame(input logic [63:0] fm);
    int e;
    drive_lines(fm);
    raise_vsync(fm, e);
  endtask

  initial begin
    logic [63:0] fm, zero;
    int          e, e2, dens;
    zero = '0;
    rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; mask = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x_c", x_c, 0);
    check("rst_y_c", y_c, 0);
    check("rst_valid", valid, 0);
    check("rst_no_obj", no_obj, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); #2 rst = 1'b0;

    // Directed frames: 2x2 block, single corner pixel, empty, full.
    fm = '0;
    for (int y = 4; y <= 5; y++) for (int x = 2; x <= 3; x++) fm[y*8+x] = 1'b1;
    frame(fm);
    fm = '0; fm[63] = 1'b1;
    frame(fm);
    frame(zero);
    fm = '1;
    frame(fm);
    wait_drain();

    // Frame end 10 cycles into DIV_X: discarded, overrun set, neighbours unaffected.
    fm = '0; fm[9] = 1'b1; fm[22] = 1'b1; fm[45] = 1'b1;
    drive_lines(fm);
    raise_vsync(fm, e);
    wait_until(e + 10);
    raise_vsync(zero, e2);
    check("overrun_edge_offset", e2 - e, 11);
    fm = 64'h00F0_0F00_3C00_0180;
    frame(fm);
    wait_drain();
    check("overrun_set", overrun, ovr_model);

    // Asynchronous reset during DIV_Y.
    fm = 64'h0000_1818_0000_0000;
    drive_lines(fm);
    raise_vsync(fm, e);
    wait_until(e + 45);
    #2 rst = 1'b1;
    #1;
    check("arst_x_c", x_c, 0);
    check("arst_y_c", y_c, 0);
    check("arst_valid", valid, 0);
    check("arst_no_obj", no_obj, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    void'(sb.pop_back());
    busy_until = -1; ovr_model = 1'b0; last_x = '0; last_y = '0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    fm = 64'h8000_0000_0000_0001;
    frame(fm);

    // Randomised frames with varying density, one guaranteed empty.
    for (int i = 0; i < 8; i++) begin
      dens = (i == 2) ? 0 : int'($urandom_range(0, 100));
      for (int b = 0; b < 64; b++) fm[b] = ($urandom_range(0, 99) < dens);
      frame(fm);
    end
    wait_drain();
    check("overrun_final", overrun, ovr_model);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
